// File: rtl/pcap_mem_dispatch_pkg.sv
// Purpose: shared constants for the pcap replay path (FSM encodings, source-port decode).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pcap_mem_dispatch_pkg;

    localparam int MAX_QUEUES = 4;
    localparam int SRC_PORT_W = 8;

    // Dispatcher FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    typedef struct packed {
        logic       hit;
        logic [1:0] qid;
    } port_dec_t;

    // Host DMA tags replay packets with a one-hot code on the odd bit positions:
    // queue q is carried on port code 1 << (2q+1).
    function automatic logic [SRC_PORT_W-1:0] port_code(input int q);
        return SRC_PORT_W'(1 << (2 * q + 1));
    endfunction

    function automatic port_dec_t decode_src_port(input logic [SRC_PORT_W-1:0] port);
        port_dec_t d;
        d = '0;
        for (int q = 0; q < MAX_QUEUES; q++) begin
            if (port == port_code(q)) begin
                d.hit = 1'b1;
                d.qid = 2'(q);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Purpose: small first-word-fallthrough FIFO; head entry visible on dout whenever !empty.
// Latency: a written word appears on dout the cycle after the write.
// Backpressure: nearly_full asserts with one slot left; writes when full and reads when empty are ignored.
// Ports: clk/rst_n, din/wr_en in, dout/rd_en head, nearly_full/empty status.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full;
    logic                      do_wr;
    logic                      do_rd;

    // depth tops out at exactly 2**MAX_DEPTH_BITS, so the MSB alone means full
    assign full        = depth[MAX_DEPTH_BITS];
    assign nearly_full = full | (&depth[MAX_DEPTH_BITS-1:0]);
    assign empty       = (depth == '0);
    assign do_wr       = wr_en & ~full;
    assign do_rd       = rd_en & ~empty;
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
            end
            if (do_wr && !do_rd) begin
                depth <= depth + (MAX_DEPTH_BITS + 1)'(1);
            end else if (!do_wr && do_rd) begin
                depth <= depth - (MAX_DEPTH_BITS + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/pcap_mem_dispatch.sv
// Purpose: buffers host-DMA replay packets and steers each to one of NUM_QUEUES memory streams by source port.
// Latency: one idle/decode bubble per packet, then one beat per cycle from the FIFO head.
// Backpressure: s_axis_tready = ~fifo nearly_full; a stalled queue blocks every later packet (strict order).
// Ports: s_axis_* input stream, m_axis_* flattened per-queue streams (queue i at slice i),
//        cnt_clear sync clear, pkt_count per-queue forwarded packets, drop_count unmapped packets.
module pcap_mem_dispatch
    import pcap_mem_dispatch_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES         = 4,
    parameter int SRC_PORT_POS       = 16,
    parameter int FIFO_DEPTH_BITS    = 6,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                                       axis_aclk,
    input  logic                                       axis_aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]               s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]             s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]              s_axis_tuser,
    input  logic                                       s_axis_tvalid,
    input  logic                                       s_axis_tlast,
    output logic                                       s_axis_tready,
    output logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [NUM_QUEUES-1:0]                      m_axis_tvalid,
    output logic [NUM_QUEUES-1:0]                      m_axis_tlast,
    input  logic [NUM_QUEUES-1:0]                      m_axis_tready,
    input  logic                                       cnt_clear,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0]            pkt_count,
    output logic [CNT_WIDTH-1:0]                       drop_count
);

    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int FW = 1 + UW + KW + DW;

    logic [FW-1:0]        fifo_dout;
    logic                 fifo_nearly_full;
    logic                 fifo_empty;
    logic                 fifo_rd;
    logic                 rst_done;
    logic [DW-1:0]        head_data;
    logic [KW-1:0]        head_keep;
    logic [UW-1:0]        head_user;
    logic                 head_last;
    logic [1:0]           state;
    logic [1:0]           sel;
    logic                 sel_rdy;
    port_dec_t            dec;
    logic                 mapped;
    logic                 pkt_done;
    logic                 drop_done;
    logic [CNT_WIDTH-1:0] pkt_cnt [NUM_QUEUES];

    // Holds s_axis_tready low for the whole reset and the first edge after it
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    assign s_axis_tready = rst_done & ~fifo_nearly_full;

    fallthrough_small_fifo #(
        .WIDTH          (FW),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk         (axis_aclk),
        .rst_n       (axis_aresetn),
        .din         ({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
        .wr_en       (s_axis_tvalid & s_axis_tready),
        .rd_en       (fifo_rd),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign head_data = fifo_dout[DW-1:0];
    assign head_keep = fifo_dout[DW +: KW];
    assign head_user = fifo_dout[DW+KW +: UW];
    assign head_last = fifo_dout[FW-1];

    // Only consulted in IDLE, where the head is always the first beat of a packet
    assign dec    = decode_src_port(head_user[SRC_PORT_POS +: SRC_PORT_W]);
    assign mapped = dec.hit && (int'(dec.qid) < NUM_QUEUES);

    assign fifo_rd   = ~fifo_empty & (((state == ST_FWD) & sel_rdy) | (state == ST_DROP));
    assign pkt_done  = fifo_rd & head_last & (state == ST_FWD);
    assign drop_done = fifo_rd & head_last & (state == ST_DROP);

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state <= ST_IDLE;
            sel   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        sel   <= dec.qid;
                        state <= mapped ? ST_FWD : ST_DROP;
                    end
                end
                ST_FWD: begin
                    if (pkt_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (drop_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Only the selected slice carries data, and only while the head is valid
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = '0;
        m_axis_tlast  = '0;
        sel_rdy       = 1'b0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (sel == 2'(q)) begin
                sel_rdy = m_axis_tready[q];
            end
            if ((state == ST_FWD) && (sel == 2'(q)) && !fifo_empty) begin
                m_axis_tvalid[q]         = 1'b1;
                m_axis_tlast[q]          = head_last;
                m_axis_tdata[q*DW +: DW] = head_data;
                m_axis_tkeep[q*KW +: KW] = head_keep;
                m_axis_tuser[q*UW +: UW] = head_user;
            end
        end
    end

    // Saturating counters; clear wins over a same-cycle increment
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                pkt_cnt[q] <= '0;
            end
            drop_count <= '0;
        end else if (cnt_clear) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                pkt_cnt[q] <= '0;
            end
            drop_count <= '0;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (pkt_done && (sel == 2'(q)) && (pkt_cnt[q] != '1)) begin
                    pkt_cnt[q] <= pkt_cnt[q] + CNT_WIDTH'(1);
                end
            end
            if (drop_done && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            pkt_count[q*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt[q];
        end
    end

endmodule
